// File: rtl/ram_port_arbiter_if.sv
// Bus bundle between the two RAM masters (core data bus M0, debug master M1),
// the arbiter and the single-port RAM.
//   m0_*/m1_*  : request (req, we, addr, wdata, wstrb) and response (gnt, rvalid, err, rdata)
//   m1_lock    : debug master asks for exclusive ownership
//   ram_*      : RAM enable, byte-lane write enables, word address, write/read data
// Modport slave is the arbiter's view; modport master is the masters' and RAM's view.
interface ram_port_arbiter_if #(
  parameter int unsigned DEPTH_W = 11
);
  logic                m0_req;
  logic                m0_we;
  logic [31:0]         m0_addr;
  logic [31:0]         m0_wdata;
  logic [3:0]          m0_wstrb;
  logic                m0_gnt;
  logic                m0_rvalid;
  logic                m0_err;
  logic [31:0]         m0_rdata;

  logic                m1_req;
  logic                m1_we;
  logic [31:0]         m1_addr;
  logic [31:0]         m1_wdata;
  logic [3:0]          m1_wstrb;
  logic                m1_lock;
  logic                m1_gnt;
  logic                m1_rvalid;
  logic                m1_err;
  logic [31:0]         m1_rdata;

  logic                ram_en;
  logic [3:0]          ram_we;
  logic [DEPTH_W-1:0]  ram_addr;
  logic [31:0]         ram_wdata;
  logic [31:0]         ram_rdata;

  modport slave (
    input  m0_req, m0_we, m0_addr, m0_wdata, m0_wstrb,
    output m0_gnt, m0_rvalid, m0_err, m0_rdata,
    input  m1_req, m1_we, m1_addr, m1_wdata, m1_wstrb, m1_lock,
    output m1_gnt, m1_rvalid, m1_err, m1_rdata,
    output ram_en, ram_we, ram_addr, ram_wdata,
    input  ram_rdata
  );

  modport master (
    output m0_req, m0_we, m0_addr, m0_wdata, m0_wstrb,
    input  m0_gnt, m0_rvalid, m0_err, m0_rdata,
    output m1_req, m1_we, m1_addr, m1_wdata, m1_wstrb, m1_lock,
    input  m1_gnt, m1_rvalid, m1_err, m1_rdata,
    input  ram_en, ram_we, ram_addr, ram_wdata,
    output ram_rdata
  );
endinterface

// File: rtl/ram_port_arbiter.sv
// Two-master arbiter in front of a single-port 32-bit RAM.
// Ports: clk, rst (synchronous, active high), bus (ram_port_arbiter_if.slave).
// Grants and the RAM access happen combinationally in the accept cycle; read
// responses (rvalid/err/rdata) appear exactly one cycle later, to the owner only.
// M1 may lock the RAM; a starvation counter forces a single M0 grant after
// MAX_WAIT waiting cycles, even while locked.
// Build option: define RAM_ARB_RR_EN for round-robin on simultaneous unlocked
// requests; otherwise M1 has fixed priority.
module ram_port_arbiter #(
  parameter int unsigned DEPTH_W  = 11,
  parameter int unsigned MAX_WAIT = 8
) (
  input  logic              clk,
  input  logic              rst,
  ram_port_arbiter_if.slave bus
);

  localparam int unsigned CNT_W = (MAX_WAIT < 1) ? 1 : $clog2(MAX_WAIT + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_WAIT);

  typedef enum logic [1:0] {IDLE, OWN_M0, OWN_M1, LOCK_M1} state_t;

  state_t            state;
  logic [CNT_W-1:0]  wait_cnt;
  logic              rv0_q, er0_q, rv1_q, er1_q;
  logic [31:0]       rd0_q, rd1_q;
`ifdef RAM_ARB_RR_EN
  logic              rr_last_m1;
`endif

  logic              gnt0_c, gnt1_c;
  logic              force_m0_c, locked_c;
  logic              oor0_c, oor1_c;
  logic              sel_we_c, sel_oor_c;
  logic [31:0]       sel_addr_c, sel_wdata_c;
  logic [3:0]        sel_wstrb_c;
  logic              ram_en_c;
  logic [31:0]       rdata0_c, rdata1_c;

  // Out of range: above the RAM window or not word aligned.
  assign oor0_c = ((bus.m0_addr >> (DEPTH_W + 2)) != 32'd0) || (bus.m0_addr[1:0] != 2'b00);
  assign oor1_c = ((bus.m1_addr >> (DEPTH_W + 2)) != 32'd0) || (bus.m1_addr[1:0] != 2'b00);

  // Per-cycle grant decision; reset suppresses every grant.
  always_comb begin
    gnt0_c     = 1'b0;
    gnt1_c     = 1'b0;
    force_m0_c = bus.m0_req && (wait_cnt == CNT_MAX);
    locked_c   = (state == LOCK_M1) && bus.m1_lock;
    if (rst) begin
      gnt0_c = 1'b0;
      gnt1_c = 1'b0;
    end else if (force_m0_c) begin
      gnt0_c = 1'b1;
    end else if (locked_c) begin
      gnt1_c = bus.m1_req;
    end else if (bus.m0_req && bus.m1_req) begin
`ifdef RAM_ARB_RR_EN
      gnt0_c = rr_last_m1;
      gnt1_c = !rr_last_m1;
`else
      gnt1_c = 1'b1;
`endif
    end else begin
      gnt0_c = bus.m0_req;
      gnt1_c = bus.m1_req;
    end
  end

  // Route the winner's request to the RAM; out-of-range accesses never reach it.
  always_comb begin
    sel_we_c    = gnt1_c ? bus.m1_we    : bus.m0_we;
    sel_addr_c  = gnt1_c ? bus.m1_addr  : bus.m0_addr;
    sel_wdata_c = gnt1_c ? bus.m1_wdata : bus.m0_wdata;
    sel_wstrb_c = gnt1_c ? bus.m1_wstrb : bus.m0_wstrb;
    sel_oor_c   = gnt1_c ? oor1_c       : oor0_c;
    ram_en_c    = (gnt0_c || gnt1_c) && !sel_oor_c;
  end

  assign bus.ram_en    = ram_en_c;
  assign bus.ram_we    = (ram_en_c && sel_we_c) ? sel_wstrb_c : 4'b0000;
  assign bus.ram_addr  = sel_addr_c[DEPTH_W+1:2];
  assign bus.ram_wdata = sel_wdata_c;

  assign bus.m0_gnt = gnt0_c;
  assign bus.m1_gnt = gnt1_c;

  // RAM data arrives in the rvalid cycle itself; outside it the last value is held.
  always_comb begin
    rdata0_c = rd0_q;
    rdata1_c = rd1_q;
    if (rv0_q) rdata0_c = er0_q ? 32'd0 : bus.ram_rdata;
    if (rv1_q) rdata1_c = er1_q ? 32'd0 : bus.ram_rdata;
    if (rst) begin
      rdata0_c = 32'd0;
      rdata1_c = 32'd0;
    end
  end

  assign bus.m0_rvalid = rv0_q && !rst;
  assign bus.m0_err    = er0_q && !rst;
  assign bus.m0_rdata  = rdata0_c;
  assign bus.m1_rvalid = rv1_q && !rst;
  assign bus.m1_err    = er1_q && !rst;
  assign bus.m1_rdata  = rdata1_c;

  // Ownership FSM, starvation counter and response pipeline.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      wait_cnt <= '0;
      rv0_q    <= 1'b0;
      er0_q    <= 1'b0;
      rv1_q    <= 1'b0;
      er1_q    <= 1'b0;
      rd0_q    <= 32'd0;
      rd1_q    <= 32'd0;
`ifdef RAM_ARB_RR_EN
      rr_last_m1 <= 1'b1;
`endif
    end else begin
      rv0_q <= gnt0_c && (!bus.m0_we || oor0_c);
      er0_q <= gnt0_c && oor0_c;
      rv1_q <= gnt1_c && (!bus.m1_we || oor1_c);
      er1_q <= gnt1_c && oor1_c;
      if (rv0_q) rd0_q <= rdata0_c;
      if (rv1_q) rd1_q <= rdata1_c;

      if (!bus.m0_req || gnt0_c) begin
        wait_cnt <= '0;
      end else if (wait_cnt != CNT_MAX) begin
        wait_cnt <= wait_cnt + CNT_W'(1);
      end

`ifdef RAM_ARB_RR_EN
      if (gnt0_c) begin
        rr_last_m1 <= 1'b0;
      end else if (gnt1_c) begin
        rr_last_m1 <= 1'b1;
      end
`endif

      if (!bus.m0_req && !bus.m1_req) begin
        state <= IDLE;
      end else if ((state == LOCK_M1) && !bus.m1_lock) begin
        state <= IDLE;
      end else if (gnt1_c) begin
        state <= bus.m1_lock ? LOCK_M1 : OWN_M1;
      end else if (gnt0_c) begin
        // A forced grant during a lock is a one-cycle interruption.
        state <= ((state == LOCK_M1) && bus.m1_lock) ? LOCK_M1 : OWN_M0;
      end
    end
  end

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Directed bench for ram_port_arbiter with a behavioural RAM and a response
// scoreboard: expected read responses are queued when a read is issued and
// compared in the cycle the DUT must answer.
module tb_ram_port_arbiter;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  ram_port_arbiter_if #(.DEPTH_W(11)) bus ();

  ram_port_arbiter #(.DEPTH_W(11), .MAX_WAIT(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Behavioural synchronous RAM: read data one cycle after ram_en with ram_we==0.
  logic [31:0] mem [0:2047];
  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 2048; i++) mem[i] <= 32'd0;
      bus.ram_rdata <= 32'd0;
    end else if (bus.ram_en) begin
      for (int l = 0; l < 4; l++)
        if (bus.ram_we[l]) mem[bus.ram_addr][8*l +: 8] <= bus.ram_wdata[8*l +: 8];
      if (bus.ram_we == 4'b0000) bus.ram_rdata <= mem[bus.ram_addr];
    end
  end

  typedef struct {
    int          cyc;
    logic [31:0] data;
    logic        err;
  } rsp_t;

  rsp_t sb0[$];
  rsp_t sb1[$];
  int   n_cmp = 0;
  int   n_err = 0;
  int   cyc   = 0;
  int   n_m0  = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic m0_drive(input logic req, input logic we, input logic [31:0] addr,
                          input logic [31:0] wdata, input logic [3:0] strb);
    bus.m0_req = req; bus.m0_we = we; bus.m0_addr = addr;
    bus.m0_wdata = wdata; bus.m0_wstrb = strb;
  endtask

  task automatic m1_drive(input logic req, input logic we, input logic [31:0] addr,
                          input logic [31:0] wdata, input logic [3:0] strb, input logic lock);
    bus.m1_req = req; bus.m1_we = we; bus.m1_addr = addr;
    bus.m1_wdata = wdata; bus.m1_wstrb = strb; bus.m1_lock = lock;
  endtask

  task automatic push0(input logic [31:0] data, input logic err);
    rsp_t e;
    e.cyc = cyc + 1; e.data = data; e.err = err;
    sb0.push_back(e);
  endtask

  task automatic push1(input logic [31:0] data, input logic err);
    rsp_t e;
    e.cyc = cyc + 1; e.data = data; e.err = err;
    sb1.push_back(e);
  endtask

  // Compare this cycle's responses against the scoreboard.
  task automatic check_rsp();
    rsp_t e;
    if (sb0.size() != 0 && sb0[0].cyc == cyc) begin
      e = sb0.pop_front();
      chk("m0_rvalid", 32'(bus.m0_rvalid), 32'd1);
      chk("m0_err",    32'(bus.m0_err),    32'(e.err));
      chk("m0_rdata",  bus.m0_rdata,       e.data);
    end else begin
      chk("m0_rvalid_quiet", 32'(bus.m0_rvalid), 32'd0);
    end
    if (sb1.size() != 0 && sb1[0].cyc == cyc) begin
      e = sb1.pop_front();
      chk("m1_rvalid", 32'(bus.m1_rvalid), 32'd1);
      chk("m1_err",    32'(bus.m1_err),    32'(e.err));
      chk("m1_rdata",  bus.m1_rdata,       e.data);
    end else begin
      chk("m1_rvalid_quiet", 32'(bus.m1_rvalid), 32'd0);
    end
  endtask

  task automatic tick();
    check_rsp();
    @(negedge clk);
    cyc++;
  endtask

  initial begin
    m0_drive(1'b0, 1'b0, 32'd0, 32'd0, 4'd0);
    m1_drive(1'b0, 1'b0, 32'd0, 32'd0, 4'd0, 1'b0);
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);

    // Reset holds everything low even with a request present.
    m0_drive(1'b1, 1'b0, 32'h10, 32'd0, 4'd0);
    #1;
    chk("rst_m0_gnt", 32'(bus.m0_gnt), 32'd0);
    chk("rst_ram_en", 32'(bus.ram_en), 32'd0);
    chk("rst_ram_we", 32'(bus.ram_we), 32'd0);
    chk("rst_m0_err", 32'(bus.m0_err), 32'd0);
    chk("rst_m0_rdata", bus.m0_rdata, 32'd0);
    tick();

    // First cycle out of reset: M0 partial write.
    rst = 1'b0;
    m0_drive(1'b1, 1'b1, 32'h10, 32'hDEADBEEF, 4'b0011);
    #1;
    chk("wr_m0_gnt", 32'(bus.m0_gnt), 32'd1);
    chk("wr_m1_gnt", 32'(bus.m1_gnt), 32'd0);
    chk("wr_ram_en", 32'(bus.ram_en), 32'd1);
    chk("wr_ram_we", 32'(bus.ram_we), 32'h3);
    chk("wr_ram_addr", 32'(bus.ram_addr), 32'd4);
    chk("wr_ram_wdata", bus.ram_wdata, 32'hDEADBEEF);
    tick();

    // Read back: only lanes 0-1 were written.
    m0_drive(1'b1, 1'b0, 32'h10, 32'd0, 4'b1111);
    #1;
    chk("rd_m0_gnt", 32'(bus.m0_gnt), 32'd1);
    chk("rd_ram_en", 32'(bus.ram_en), 32'd1);
    chk("rd_ram_we", 32'(bus.ram_we), 32'd0);
    chk("rd_ram_addr", 32'(bus.ram_addr), 32'd4);
    push0(32'h0000BEEF, 1'b0);
    tick();

    m0_drive(1'b0, 1'b0, 32'd0, 32'd0, 4'd0);
    #1;
    chk("idle_m0_gnt", 32'(bus.m0_gnt), 32'd0);
    chk("idle_ram_en", 32'(bus.ram_en), 32'd0);
    tick();
    chk("hold_m0_rdata", bus.m0_rdata, 32'h0000BEEF);

    // Address above the RAM window.
    m0_drive(1'b1, 1'b0, 32'h00002000, 32'd0, 4'd0);
    #1;
    chk("oor_m0_gnt", 32'(bus.m0_gnt), 32'd1);
    chk("oor_ram_en", 32'(bus.ram_en), 32'd0);
    push0(32'd0, 1'b1);
    tick();

    // Misaligned M1 write: granted, no RAM write, error response.
    m0_drive(1'b0, 1'b0, 32'd0, 32'd0, 4'd0);
    m1_drive(1'b1, 1'b1, 32'h11, 32'h12345678, 4'b1111, 1'b0);
    #1;
    chk("mis_m1_gnt", 32'(bus.m1_gnt), 32'd1);
    chk("mis_ram_en", 32'(bus.ram_en), 32'd0);
    chk("mis_ram_we", 32'(bus.ram_we), 32'd0);
    push1(32'd0, 1'b1);
    tick();

    // Highest in-range word.
    m1_drive(1'b1, 1'b0, 32'h00001FFC, 32'd0, 4'd0, 1'b0);
    #1;
    chk("top_ram_en", 32'(bus.ram_en), 32'd1);
    chk("top_ram_addr", 32'(bus.ram_addr), 32'h7FF);
    push1(32'd0, 1'b0);
    tick();

    // M1 reads the written word so its rdata register is non-zero.
    m1_drive(1'b1, 1'b0, 32'h10, 32'd0, 4'd0, 1'b0);
    #1;
    chk("m1rd_gnt", 32'(bus.m1_gnt), 32'd1);
    push1(32'h0000BEEF, 1'b0);
    tick();
    m1_drive(1'b0, 1'b0, 32'd0, 32'd0, 4'd0, 1'b0);
    tick();

    // Reset in the cycle of an M1 read: nothing granted, nothing returned.
    rst = 1'b1;
    m1_drive(1'b1, 1'b0, 32'h10, 32'd0, 4'd0, 1'b0);
    #1;
    chk("rstgnt_m1_gnt", 32'(bus.m1_gnt), 32'd0);
    chk("rstgnt_ram_en", 32'(bus.ram_en), 32'd0);
    tick();
    rst = 1'b0;
    m1_drive(1'b0, 1'b0, 32'd0, 32'd0, 4'd0, 1'b0);
    #1;
    chk("postrst_m1_rdata", bus.m1_rdata, 32'd0);
    chk("postrst_m1_err", 32'(bus.m1_err), 32'd0);
    chk("postrst_m0_gnt", 32'(bus.m0_gnt), 32'd0);
    chk("postrst_ram_en", 32'(bus.ram_en), 32'd0);
    tick();

    // Simultaneous unlocked writes for four cycles.
    m0_drive(1'b1, 1'b1, 32'h20, 32'h0A0A0A0A, 4'b1111);
    m1_drive(1'b1, 1'b1, 32'h40, 32'h0B0B0B0B, 4'b1111, 1'b0);
    for (int k = 0; k < 4; k++) begin
      logic exp_m0;
`ifdef RAM_ARB_RR_EN
      exp_m0 = (k % 2 == 0);
`else
      exp_m0 = 1'b0;
`endif
      #1;
      chk("arb_m0_gnt", 32'(bus.m0_gnt), 32'(exp_m0));
      chk("arb_m1_gnt", 32'(bus.m1_gnt), 32'(!exp_m0));
      chk("arb_ram_addr", 32'(bus.ram_addr), exp_m0 ? 32'd8 : 32'd16);
      tick();
    end
    m0_drive(1'b0, 1'b0, 32'd0, 32'd0, 4'd0);
    m1_drive(1'b0, 1'b0, 32'd0, 32'd0, 4'd0, 1'b0);
    tick();

    // M1 takes the lock alone, then M0 competes continuously.
    m1_drive(1'b1, 1'b1, 32'h40, 32'h0C0C0C0C, 4'b1111, 1'b1);
    #1;
    chk("lock_take_m1_gnt", 32'(bus.m1_gnt), 32'd1);
    tick();
    m0_drive(1'b1, 1'b1, 32'h20, 32'h0D0D0D0D, 4'b1111);
    for (int k = 0; k < 27; k++) begin
      logic exp_m0;
      exp_m0 = (k % 9 == 8);
      #1;
      chk("lock_m0_gnt", 32'(bus.m0_gnt), 32'(exp_m0));
      chk("lock_m1_gnt", 32'(bus.m1_gnt), 32'(!exp_m0));
      if (bus.m0_gnt) n_m0++;
      tick();
    end
    chk("lock_m0_count", 32'(n_m0), 32'd3);

    m0_drive(1'b0, 1'b0, 32'd0, 32'd0, 4'd0);
    m1_drive(1'b0, 1'b0, 32'd0, 32'd0, 4'd0, 1'b0);
    tick();
    tick();
    chk("sb_drain", 32'(sb0.size() + sb1.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
